// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access encodings, FSM states
// and the func3-to-access-size mapping.
package data_mem_ctrl_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } mem_width_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dm_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } access_size_t;

    // Unlisted encodings (3, 6, 7) fall through to a full-word access.
    function automatic access_size_t accessSize(input logic [2:0] func3);
        case (func3)
            3'd0, 3'd4: return SZ_BYTE;
            3'd1, 3'd5: return SZ_HALF;
            default:    return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_ram.sv
// Single-port word-organised RAM with per-byte write enables and a registered read.
// Read returns the word held before any same-cycle write.
module dm_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle load/store controller for the MEM stage with byte/half/word lanes.
// Optional misaligned-access trap is enabled by defining DM_MISALIGN_TRAP_EN.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DM_MEM_DEPTH = 4096,
    parameter int DATA_WIDTH   = 32,
    parameter int FUNC3_WIDTH  = 3,
    parameter int LATENCY      = 2
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   memReadMeM,
    input  logic                   memWriteMeM,
    input  logic [FUNC3_WIDTH-1:0] func3MeM,
    input  logic [DATA_WIDTH-1:0]  aluOutMeM,
    input  logic [DATA_WIDTH-1:0]  rs2DataMeM,
    output logic [DATA_WIDTH-1:0]  dMOutMem,
    output logic                   dMReadyMem,
    output logic                   misalignErr,
    output dm_state_t              stateDbg
);

    localparam int AW = $clog2(DM_MEM_DEPTH);

    // Handshake: a request is held by the processor from the cycle it is raised
    // until it observes dMReadyMem high; the request is consumed only in IDLE
    // and ignored in BUSY/DONE, so holding it through DONE never re-issues it.
    dm_state_t              state;
    logic [3:0]             cnt;
    logic [AW+1:0]          addrQ;
    logic [FUNC3_WIDTH-1:0] func3Q;
    logic [DATA_WIDTH-1:0]  dataQ;
    logic                   isStoreQ;
    logic                   misErrQ;

    logic          request;
    logic          execute;
    access_size_t  size;
    logic [1:0]    lane;
    logic          misaligned;
    logic [AW-1:0] ramAddr;
    logic [3:0]    ramWe;
    logic [31:0]   ramWdata;
    logic [31:0]   ramRdata;
    logic [31:0]   shifted;
    logic [31:0]   loadValue;
    logic          unusedAddrHi;

    assign request      = memReadMeM | memWriteMeM;
    assign execute      = (state == BUSY) && (cnt == 4'd1);
    assign dMReadyMem   = ((state == IDLE) && !request) || (state == DONE);
    assign misalignErr  = misErrQ;
    assign stateDbg     = state;
    assign unusedAddrHi = ^aluOutMeM[DATA_WIDTH-1:AW+2];

    // Presenting the incoming address while IDLE lets the registered read be
    // ready by the first BUSY cycle, so LATENCY=1 still returns valid data.
    assign ramAddr = (state == IDLE) ? aluOutMeM[AW+1:2] : addrQ[AW+1:2];

    always_comb begin
        size = accessSize(func3Q);
`ifdef DM_MISALIGN_TRAP_EN
        lane       = addrQ[1:0];
        misaligned = ((size == SZ_HALF) && addrQ[0]) ||
                     ((size == SZ_WORD) && (addrQ[1:0] != 2'b00));
`else
        misaligned = 1'b0;
        case (size)
            SZ_HALF: lane = {addrQ[1], 1'b0};
            SZ_WORD: lane = 2'b00;
            default: lane = addrQ[1:0];
        endcase
`endif
    end

    always_comb begin
        ramWe    = 4'b0000;
        ramWdata = dataQ;
        case (size)
            SZ_BYTE: begin
                ramWe    = 4'b0001 << lane;
                ramWdata = {4{dataQ[7:0]}};
            end
            SZ_HALF: begin
                ramWe    = lane[1] ? 4'b1100 : 4'b0011;
                ramWdata = {2{dataQ[15:0]}};
            end
            default: ramWe = 4'b1111;
        endcase
        if (!(execute && isStoreQ && !misaligned && rstN)) begin
            ramWe = 4'b0000;
        end
    end

    always_comb begin
        shifted = ramRdata >> {lane, 3'b000};
        case (func3Q)
            LB:      loadValue = {{24{shifted[7]}}, shifted[7:0]};
            LH:      loadValue = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     loadValue = {24'd0, shifted[7:0]};
            LHU:     loadValue = {16'd0, shifted[15:0]};
            default: loadValue = ramRdata;
        endcase
    end

    dm_ram #(
        .DEPTH (DM_MEM_DEPTH),
        .AW    (AW)
    ) uRam (
        .clk   (clk),
        .addr  (ramAddr),
        .we    (ramWe),
        .wdata (ramWdata),
        .rdata (ramRdata)
    );

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addrQ    <= '0;
            func3Q   <= '0;
            dataQ    <= '0;
            isStoreQ <= 1'b0;
            dMOutMem <= '0;
            misErrQ  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        addrQ    <= aluOutMeM[AW+1:0];
                        func3Q   <= func3MeM;
                        dataQ    <= rs2DataMeM;
                        isStoreQ <= memWriteMeM;
                        cnt      <= 4'(LATENCY);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DONE;
                        if (!isStoreQ) begin
                            dMOutMem <= misaligned ? '0 : loadValue;
                        end
                        if (misaligned) begin
                            misErrQ <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed and randomized load/store checks of data_mem_ctrl against a byte-level
// memory model; misaligned expectations follow DM_MISALIGN_TRAP_EN.
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rstN;
    logic        memReadMeM;
    logic        memWriteMeM;
    logic [2:0]  func3MeM;
    logic [31:0] aluOutMeM;
    logic [31:0] rs2DataMeM;
    logic [31:0] dMOutMem;
    logic        dMReadyMem;
    logic        misalignErr;
    dm_state_t   stateDbg;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]  mem_b [int unsigned];
    logic [31:0] last_load = 32'd0;
    logic        exp_err   = 1'b0;

    logic [2:0]  ld_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    logic [2:0]  st_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    logic [31:0] r_addr;
    logic [31:0] r_exp;
    logic [2:0]  r_f3;

    data_mem_ctrl #(
        .DM_MEM_DEPTH (4096),
        .DATA_WIDTH   (32),
        .FUNC3_WIDTH  (3),
        .LATENCY      (LAT)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .memReadMeM  (memReadMeM),
        .memWriteMeM (memWriteMeM),
        .func3MeM    (func3MeM),
        .aluOutMeM   (aluOutMeM),
        .rs2DataMeM  (rs2DataMeM),
        .dMOutMem    (dMOutMem),
        .dMReadyMem  (dMReadyMem),
        .misalignErr (misalignErr),
        .stateDbg    (stateDbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    // Byte-addressed model: 4096 words = 16 KiB, so address bits above 13 alias.
    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        int unsigned a;
        int sz;
        sz = size_of(f3);
        a  = addr & 32'h3FFF;
        if ((a % sz) != 0) begin
`ifdef DM_MISALIGN_TRAP_EN
            exp_err = 1'b1;
            return;
`else
            a = a - (a % sz);
`endif
        end
        for (int i = 0; i < sz; i++) mem_b[a + i] = data[8*i +: 8];
    endtask

    task automatic model_load(input logic [2:0] f3, input logic [31:0] addr, output logic [31:0] val);
        int unsigned a;
        int sz;
        sz  = size_of(f3);
        a   = addr & 32'h3FFF;
        val = 32'd0;
        if ((a % sz) != 0) begin
`ifdef DM_MISALIGN_TRAP_EN
            exp_err = 1'b1;
            return;
`else
            a = a - (a % sz);
`endif
        end
        for (int i = 0; i < sz; i++) val[8*i +: 8] = mem_b.exists(a + i) ? mem_b[a + i] : 8'h00;
        if (f3 == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
        if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
    endtask

    // One complete access; hold=0 drops the request after the first BUSY edge.
    task automatic access(input bit rd, input bit wr, input bit hold, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_out, input string tag);
        int low_cycles;
        @(posedge clk); #1;
        memReadMeM  = rd;
        memWriteMeM = wr;
        func3MeM    = f3;
        aluOutMeM   = addr;
        rs2DataMeM  = data;
        low_cycles  = 0;
        if (!hold) begin
            @(posedge clk); #1;
            memReadMeM  = 1'b0;
            memWriteMeM = 1'b0;
            low_cycles  = 1;
        end
        @(negedge clk);
        while (!dMReadyMem && low_cycles < 40) begin
            low_cycles++;
            @(negedge clk);
        end
        check({tag, "_lat"}, low_cycles, LAT + 1);
        check({tag, "_out"}, dMOutMem, exp_out);
        check({tag, "_err"}, {31'd0, misalignErr}, {31'd0, exp_err});
        @(posedge clk); #1;
        memReadMeM  = 1'b0;
        memWriteMeM = 1'b0;
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                            input string tag, input bit also_rd = 1'b0, input bit hold = 1'b1);
        model_store(f3, addr, data);
        access(also_rd, 1'b1, hold, f3, addr, data, last_load, tag);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp,
                           input string tag, input bit hold = 1'b1);
        logic [31:0] unused_model;
        model_load(f3, addr, unused_model);
        access(1'b1, 1'b0, hold, f3, addr, $urandom, exp, tag);
        last_load = exp;
    endtask

    initial begin
        rstN        = 1'b0;
        memReadMeM  = 1'b0;
        memWriteMeM = 1'b0;
        func3MeM    = 3'd0;
        aluOutMeM   = 32'd0;
        rs2DataMeM  = 32'd0;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, dMReadyMem}, 32'd1);
        check("rst_out",   dMOutMem, 32'd0);
        check("rst_err",   {31'd0, misalignErr}, 32'd0);
        check("rst_state", {30'd0, stateDbg}, {30'd0, IDLE});

        do_store(3'd2, 32'h10, 32'hDEAD_BEEF, "sw10");
        do_load (3'd2, 32'h10, 32'hDEAD_BEEF, "lw10");
        do_store(3'd0, 32'h13, 32'h0000_0080, "sb13");
        do_load (3'd0, 32'h13, 32'hFFFF_FF80, "lb13");
        do_load (3'd4, 32'h13, 32'h0000_0080, "lbu13");
        do_load (3'd2, 32'h10, 32'h80AD_BEEF, "lw10_b", 1'b0);
        do_store(3'd2, 32'h20, 32'h1111_2222, "sw20");
        do_store(3'd1, 32'h22, 32'h0000_8001, "sh22", 1'b0, 1'b0);
        do_load (3'd1, 32'h22, 32'hFFFF_8001, "lh22");
        do_load (3'd5, 32'h22, 32'h0000_8001, "lhu22");
        do_load (3'd1, 32'h20, 32'h0000_2222, "lh20");
        do_load (3'd2, 32'h4010, 32'h80AD_BEEF, "lw4010_alias");
        do_store(3'd0, 32'h21, 32'hFFFF_FF7F, "sb21_both", 1'b1);
        do_load (3'd5, 32'h20, 32'h0000_7F22, "lhu20");

        // Store aborted by reset on its second cycle must leave the RAM untouched.
        do_store(3'd2, 32'h30, 32'hCAFE_F00D, "sw30");
        do_load (3'd2, 32'h10, 32'h80AD_BEEF, "lw10_c");
        @(posedge clk); #1;
        memWriteMeM = 1'b1;
        func3MeM    = 3'd2;
        aluOutMeM   = 32'h30;
        rs2DataMeM  = 32'h1234_5678;
        @(posedge clk); #1;
        rstN        = 1'b0;
        memWriteMeM = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'd0, dMReadyMem}, 32'd1);
        check("abort_out",   dMOutMem, 32'd0);
        check("abort_state", {30'd0, stateDbg}, {30'd0, IDLE});
        last_load = 32'd0;
        exp_err   = 1'b0;
        do_load (3'd2, 32'h30, 32'hCAFE_F00D, "lw30_after_abort");

`ifdef DM_MISALIGN_TRAP_EN
        do_load (3'd2, 32'h12, 32'h0000_0000, "lw12_mis");
        do_store(3'd2, 32'h12, 32'h55AA_55AA, "sw12_mis");
        do_load (3'd2, 32'h10, 32'h80AD_BEEF, "lw10_after_mis");
`else
        do_load (3'd2, 32'h12, 32'h80AD_BEEF, "lw12_forced");
        do_store(3'd2, 32'h12, 32'h55AA_55AA, "sw12_forced");
        do_load (3'd2, 32'h10, 32'h55AA_55AA, "lw10_after_forced");
`endif

        for (int w = 0; w < 16; w++) begin
            do_store(3'd2, 32'h100 + 32'(4 * w), $urandom, "rnd_init");
        end
        for (int i = 0; i < 40; i++) begin
            r_addr = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) r_addr = r_addr | (32'h4000 << $urandom_range(0, 4));
            if ($urandom_range(0, 1) == 1) begin
                r_f3 = st_f3[$urandom_range(0, 5)];
                do_store(r_f3, r_addr, $urandom, "rnd_st", 1'b0, 1'($urandom_range(0, 1)));
            end else begin
                r_f3 = ld_f3[$urandom_range(0, 7)];
                model_load(r_f3, r_addr, r_exp);
                do_load(r_f3, r_addr, r_exp, "rnd_ld", 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
